ex_mem_stage: RTL and testbench
===============================

EX_MEM_STAGE -- requirements
Module: ex_mem_stage

Interface
REQ-001 SHALL have parameter DATA_W, default 16, meaning the datapath width of the ALU result and store data.
REQ-002 SHALL have parameter RADDR_W, default 3, meaning the register-file address width (8 registers).
REQ-003 SHALL have port clk  input  1  rising-edge clock, the only clock.
REQ-004 SHALL have port reset  input  1  synchronous, active-high reset.
REQ-005 SHALL have port in_valid  input  1  EX stage presents an entry.
REQ-006 SHALL have port in_ready  output  1  stage can accept an entry this cycle.
REQ-007 SHALL have ports ex_result input DATA_W (ALU result), ex_zero input 1 (ALU zero flag), ex_wdata input DATA_W (store data), ex_rd input RADDR_W (destination register).
REQ-008 SHALL have input 1-bit controls ex_reg_write, ex_mem_read, ex_mem_write, ex_mem_to_reg, ex_branch, plus ex_branch_target input DATA_W.
REQ-009 SHALL have port flush  input  1  discard all held entries.
REQ-010 SHALL have ports out_valid output 1 and out_ready input 1, the MEM-side handshake.
REQ-011 SHALL have outputs mem_result DATA_W, mem_wdata DATA_W, mem_rd RADDR_W, and mem_reg_write, mem_mem_read, mem_mem_write, mem_mem_to_reg, all 1 bit, carrying the head entry.
REQ-012 SHALL have outputs branch_taken 1 and branch_target DATA_W.
REQ-013 SHALL have outputs fwd_valid 1, fwd_rd RADDR_W, fwd_data DATA_W, and load_hazard 1.

Function
REQ-014 SHALL hold up to 2 entries in FIFO order (skid buffer); count is 0, 1 or 2.
REQ-015 SHALL accept an entry only on a cycle with in_valid=1 and in_ready=1; in_ready SHALL be 1 exactly when count<2 and SHALL be driven from registered state only.
REQ-016 SHALL set out_valid=1 exactly when count>0; the head entry retires on a cycle with out_valid=1 and out_ready=1.
REQ-017 SHALL show an entry accepted while count=0 on mem_* in the next cycle (1-cycle latency).
REQ-018 SHALL, on simultaneous accept and retire at count=1, keep count=1 and present the new entry as head next cycle.
REQ-019 SHALL hold mem_* stable while out_valid=1 and out_ready=0.
REQ-020 SHALL, when flush=1, set count=0 next cycle and drop any entry offered that same cycle; flush SHALL take priority over accept and retire.
REQ-021 SHALL pulse branch_taken for exactly one cycle, the cycle after accepting an entry with ex_branch=1 and ex_zero=1 (beq), and SHALL register ex_branch_target into branch_target on that cycle; branch entries SHALL still be stored with their controls.
REQ-022 SHALL set fwd_valid=1 when out_valid=1, mem_reg_write=1, mem_mem_to_reg=0 and mem_rd!=0, with fwd_rd=mem_rd and fwd_data=mem_result.
REQ-023 SHALL set load_hazard=1 when out_valid=1, mem_mem_read=1 and mem_rd!=0; fwd_valid SHALL be 0 then.
REQ-024 SHALL gate mem_reg_write, mem_mem_read and mem_mem_write with out_valid so that no control asserts while empty.

Reset
REQ-025 SHALL, on reset=1 at a clk edge, set count=0, in_ready=1, out_valid=0, branch_taken=0, fwd_valid=0, load_hazard=0, and all data outputs to 0.
REQ-026 SHALL let reset mid-transfer discard both entries and take priority over flush and in_valid.

Structure
REQ-027 SHALL take DATA_W, RADDR_W and the packed control-bundle field positions (reg_write, mem_read, mem_write, mem_to_reg) from the shared processor package.
REQ-028 SHALL implement storage as one sub-module, skid_buffer2, parameterised on payload width; branch and forwarding logic stays in ex_mem_stage.

Verification
REQ-029 Reset, then accept ex_result=16'h0012, ex_rd=3, ex_reg_write=1 -> next cycle out_valid=1, mem_result=16'h0012, fwd_valid=1, fwd_rd=3, fwd_data=16'h0012.
REQ-030 out_ready=0, offer 3 back-to-back entries A,B,C -> A,B held, in_ready=0 after 2nd accept, C not accepted; then out_ready=1 -> A then B retired in order.
REQ-031 ex_branch=1, ex_zero=1, ex_branch_target=16'h0040 -> branch_taken=1 for one cycle with branch_target=16'h0040; same with ex_zero=0 -> branch_taken stays 0.
REQ-032 Load entry ex_mem_read=1, ex_mem_to_reg=1, ex_rd=5 -> load_hazard=1, fwd_valid=0; entry with ex_rd=0, ex_reg_write=1 -> fwd_valid=0.
REQ-033 count=2, assert flush together with in_valid=1 -> next cycle out_valid=0, in_ready=1, no entry retained.
REQ-034 count=1, pulse reset with in_valid=1 and out_ready=1 -> all outputs at REQ-025 values the next cycle.

Source files
------------

// File: rtl/ex_mem_stage_pkg.sv
// Shared processor constants: datapath widths and the packed control-bundle layout
// used between pipeline stages.
package ex_mem_stage_pkg;

  localparam int DATA_W  = 16;
  localparam int RADDR_W = 3;

  // Bit positions inside the packed control bundle
  localparam int CTL_W          = 4;
  localparam int CTL_REG_WRITE  = 0;
  localparam int CTL_MEM_READ   = 1;
  localparam int CTL_MEM_WRITE  = 2;
  localparam int CTL_MEM_TO_REG = 3;

endpackage

// File: rtl/ex_mem_stage_skid_buffer2.sv
// Two-entry FIFO skid buffer with valid/ready handshakes on both sides.
// in_ready comes straight from the occupancy register, so there is no in-to-out ready path.
module skid_buffer2 #(
  parameter int WIDTH = 8
) (
  input  logic             clk,
  input  logic             reset,
  input  logic             flush,
  input  logic             in_valid,
  output logic             in_ready,
  input  logic [WIDTH-1:0] in_data,
  output logic             out_valid,
  input  logic             out_ready,
  output logic [WIDTH-1:0] out_data
);

  logic [1:0]       count_reg, count_next;
  logic [WIDTH-1:0] head_reg, head_next;
  logic [WIDTH-1:0] tail_reg, tail_next;
  logic             push, pop;

  assign in_ready  = (count_reg != 2'd2);
  assign out_valid = (count_reg != 2'd0);
  assign out_data  = head_reg;

  assign push = in_valid & in_ready & ~flush;
  assign pop  = out_valid & out_ready & ~flush;

  always_comb begin
    count_next = count_reg;
    head_next  = head_reg;
    tail_next  = tail_reg;
    if (flush) begin
      count_next = 2'd0;
    end else begin
      case (count_reg)
        2'd0: if (push) begin
          head_next  = in_data;
          count_next = 2'd1;
        end
        2'd1: begin
          if (push && pop) begin
            head_next = in_data;
          end else if (push) begin
            tail_next  = in_data;
            count_next = 2'd2;
          end else if (pop) begin
            count_next = 2'd0;
          end
        end
        default: if (pop) begin
          // Full: no push is possible, the tail just moves up
          head_next  = tail_reg;
          count_next = 2'd1;
        end
      endcase
    end
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      count_reg <= 2'd0;
      head_reg  <= '0;
      tail_reg  <= '0;
    end else begin
      count_reg <= count_next;
      head_reg  <= head_next;
      tail_reg  <= tail_next;
    end
  end

endmodule

// File: rtl/ex_mem_stage.sv
// EX/MEM pipeline register: two-deep skid buffer for the EX payload, plus beq
// resolution and forwarding / load-use hazard signals from the head entry.
module ex_mem_stage #(
  parameter int DATA_W  = ex_mem_stage_pkg::DATA_W,
  parameter int RADDR_W = ex_mem_stage_pkg::RADDR_W
) (
  input  logic               clk,
  input  logic               reset,
  input  logic               in_valid,
  output logic               in_ready,
  input  logic [DATA_W-1:0]  ex_result,
  input  logic               ex_zero,
  input  logic [DATA_W-1:0]  ex_wdata,
  input  logic [RADDR_W-1:0] ex_rd,
  input  logic               ex_reg_write,
  input  logic               ex_mem_read,
  input  logic               ex_mem_write,
  input  logic               ex_mem_to_reg,
  input  logic               ex_branch,
  input  logic [DATA_W-1:0]  ex_branch_target,
  input  logic               flush,
  output logic               out_valid,
  input  logic               out_ready,
  output logic [DATA_W-1:0]  mem_result,
  output logic [DATA_W-1:0]  mem_wdata,
  output logic [RADDR_W-1:0] mem_rd,
  output logic               mem_reg_write,
  output logic               mem_mem_read,
  output logic               mem_mem_write,
  output logic               mem_mem_to_reg,
  output logic               branch_taken,
  output logic [DATA_W-1:0]  branch_target,
  output logic               fwd_valid,
  output logic [RADDR_W-1:0] fwd_rd,
  output logic [DATA_W-1:0]  fwd_data,
  output logic               load_hazard
);

  import ex_mem_stage_pkg::*;

  localparam int PAYLOAD_W = CTL_W + RADDR_W + 2 * DATA_W;
  localparam int WDATA_LSB = DATA_W;
  localparam int RD_LSB    = 2 * DATA_W;
  localparam int CTL_LSB   = 2 * DATA_W + RADDR_W;

  logic [CTL_W-1:0]     ex_ctl, head_ctl;
  logic [PAYLOAD_W-1:0] in_payload, head_payload;
  logic                 accept;
  logic                 branch_taken_reg;
  logic [DATA_W-1:0]    branch_target_reg;

  always_comb begin
    ex_ctl                 = '0;
    ex_ctl[CTL_REG_WRITE]  = ex_reg_write;
    ex_ctl[CTL_MEM_READ]   = ex_mem_read;
    ex_ctl[CTL_MEM_WRITE]  = ex_mem_write;
    ex_ctl[CTL_MEM_TO_REG] = ex_mem_to_reg;
  end

  assign in_payload = {ex_ctl, ex_rd, ex_wdata, ex_result};

  skid_buffer2 #(.WIDTH(PAYLOAD_W)) u_buf (
    .clk       (clk),
    .reset     (reset),
    .flush     (flush),
    .in_valid  (in_valid),
    .in_ready  (in_ready),
    .in_data   (in_payload),
    .out_valid (out_valid),
    .out_ready (out_ready),
    .out_data  (head_payload)
  );

  assign head_ctl       = head_payload[CTL_LSB +: CTL_W];
  assign mem_result     = head_payload[DATA_W-1:0];
  assign mem_wdata      = head_payload[WDATA_LSB +: DATA_W];
  assign mem_rd         = head_payload[RD_LSB +: RADDR_W];
  // Stale payload may linger after a flush, so side-effecting controls need out_valid
  assign mem_reg_write  = out_valid & head_ctl[CTL_REG_WRITE];
  assign mem_mem_read   = out_valid & head_ctl[CTL_MEM_READ];
  assign mem_mem_write  = out_valid & head_ctl[CTL_MEM_WRITE];
  assign mem_mem_to_reg = head_ctl[CTL_MEM_TO_REG];

  assign accept = in_valid & in_ready & ~flush;

  always_ff @(posedge clk) begin
    if (reset) begin
      branch_taken_reg  <= 1'b0;
      branch_target_reg <= '0;
    end else begin
      branch_taken_reg <= accept & ex_branch & ex_zero;
      if (accept && ex_branch && ex_zero) begin
        branch_target_reg <= ex_branch_target;
      end
    end
  end

  assign branch_taken  = branch_taken_reg;
  assign branch_target = branch_target_reg;

  // A load's value is not ready yet, so it raises a hazard instead of forwarding
  assign load_hazard = out_valid & mem_mem_read & (mem_rd != '0);
  assign fwd_valid   = out_valid & mem_reg_write & ~mem_mem_to_reg & (mem_rd != '0)
                       & ~load_hazard;
  assign fwd_rd      = mem_rd;
  assign fwd_data    = mem_result;

endmodule

// File: tb/tb_ex_mem_stage.sv
// Directed testbench for ex_mem_stage with hand-computed expected values.
module tb_ex_mem_stage;

  localparam int DW = 16;
  localparam int RW = 3;

  logic          clk = 1'b0;
  logic          reset, in_valid, in_ready, ex_zero, flush, out_valid, out_ready;
  logic [DW-1:0] ex_result, ex_wdata, ex_branch_target;
  logic [RW-1:0] ex_rd;
  logic          ex_reg_write, ex_mem_read, ex_mem_write, ex_mem_to_reg, ex_branch;
  logic [DW-1:0] mem_result, mem_wdata, branch_target, fwd_data;
  logic [RW-1:0] mem_rd, fwd_rd;
  logic          mem_reg_write, mem_mem_read, mem_mem_write, mem_mem_to_reg;
  logic          branch_taken, fwd_valid, load_hazard;

  int n_cmp = 0;
  int n_bad = 0;

  always #5 clk = ~clk;

  ex_mem_stage dut (
    .clk(clk), .reset(reset), .in_valid(in_valid), .in_ready(in_ready),
    .ex_result(ex_result), .ex_zero(ex_zero), .ex_wdata(ex_wdata), .ex_rd(ex_rd),
    .ex_reg_write(ex_reg_write), .ex_mem_read(ex_mem_read), .ex_mem_write(ex_mem_write),
    .ex_mem_to_reg(ex_mem_to_reg), .ex_branch(ex_branch), .ex_branch_target(ex_branch_target),
    .flush(flush), .out_valid(out_valid), .out_ready(out_ready),
    .mem_result(mem_result), .mem_wdata(mem_wdata), .mem_rd(mem_rd),
    .mem_reg_write(mem_reg_write), .mem_mem_read(mem_mem_read), .mem_mem_write(mem_mem_write),
    .mem_mem_to_reg(mem_mem_to_reg), .branch_taken(branch_taken), .branch_target(branch_target),
    .fwd_valid(fwd_valid), .fwd_rd(fwd_rd), .fwd_data(fwd_data), .load_hazard(load_hazard)
  );

  task automatic check_val(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_cmp++;
    if (got !== exp) begin
      n_bad++;
      $display("FAIL %s: got %h expected %h", tag, got, exp);
    end else begin
      $display("ok   %s = %h", tag, got);
    end
  endtask

  // Advance one clock; inputs are driven and outputs sampled 1 ns after the edge
  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic idle_inputs();
    in_valid = 0; ex_result = '0; ex_zero = 0; ex_wdata = '0; ex_rd = '0;
    ex_reg_write = 0; ex_mem_read = 0; ex_mem_write = 0; ex_mem_to_reg = 0;
    ex_branch = 0; ex_branch_target = '0; flush = 0;
  endtask

  task automatic offer(input logic [DW-1:0] res, input logic [RW-1:0] rd,
                       input logic rw, input logic mr, input logic mw, input logic m2r);
    in_valid = 1; ex_result = res; ex_wdata = res ^ 16'hFFFF; ex_rd = rd;
    ex_reg_write = rw; ex_mem_read = mr; ex_mem_write = mw; ex_mem_to_reg = m2r;
  endtask

  task automatic check_reset_state(input string pfx);
    check_val({pfx, "_in_ready"}, 32'(in_ready), 32'd1);
    check_val({pfx, "_out_valid"}, 32'(out_valid), 32'd0);
    check_val({pfx, "_branch_taken"}, 32'(branch_taken), 32'd0);
    check_val({pfx, "_branch_target"}, 32'(branch_target), 32'd0);
    check_val({pfx, "_fwd_valid"}, 32'(fwd_valid), 32'd0);
    check_val({pfx, "_load_hazard"}, 32'(load_hazard), 32'd0);
    check_val({pfx, "_mem_result"}, 32'(mem_result), 32'd0);
    check_val({pfx, "_mem_wdata"}, 32'(mem_wdata), 32'd0);
    check_val({pfx, "_mem_rd"}, 32'(mem_rd), 32'd0);
    check_val({pfx, "_mem_ctl"}, 32'({mem_reg_write, mem_mem_read, mem_mem_write}), 32'd0);
  endtask

  initial begin
    idle_inputs();
    out_ready = 0;
    reset = 1;
    tick(); tick();
    reset = 0;
    check_reset_state("rst");

    // Single accept, visible next cycle, forwarded
    offer(16'h0012, 3'd3, 1, 0, 0, 0);
    tick();
    idle_inputs();
    check_val("single_out_valid", 32'(out_valid), 32'd1);
    check_val("single_mem_result", 32'(mem_result), 32'h0012);
    check_val("single_mem_wdata", 32'(mem_wdata), 32'hFFED);
    check_val("single_fwd_valid", 32'(fwd_valid), 32'd1);
    check_val("single_fwd_rd", 32'(fwd_rd), 32'd3);
    check_val("single_fwd_data", 32'(fwd_data), 32'h0012);
    out_ready = 1;
    tick();
    check_val("single_retired", 32'(out_valid), 32'd0);
    check_val("empty_reg_write_gated", 32'(mem_reg_write), 32'd0);

    // Back-pressure: A, B held; C refused
    out_ready = 0;
    offer(16'h00A1, 3'd1, 1, 0, 0, 0);
    tick();
    check_val("bp_ready_after_A", 32'(in_ready), 32'd1);
    offer(16'h00B2, 3'd2, 1, 0, 0, 0);
    tick();
    check_val("bp_ready_after_B", 32'(in_ready), 32'd0);
    offer(16'h00C3, 3'd4, 1, 0, 0, 0);
    tick();
    idle_inputs();
    check_val("bp_hold_head", 32'(mem_result), 32'h00A1);
    check_val("bp_hold_valid", 32'(out_valid), 32'd1);
    out_ready = 1;
    tick();
    check_val("bp_second_B", 32'(mem_result), 32'h00B2);
    check_val("bp_ready_reopen", 32'(in_ready), 32'd1);
    tick();
    check_val("bp_C_dropped", 32'(out_valid), 32'd0);

    // Accept and retire together at count=1
    offer(16'h00D4, 3'd5, 1, 0, 0, 0);
    tick();
    offer(16'h00E5, 3'd6, 1, 0, 0, 0);
    tick();
    idle_inputs();
    check_val("swap_head_E", 32'(mem_result), 32'h00E5);
    check_val("swap_count1_ready", 32'(in_ready), 32'd1);
    tick();
    check_val("swap_drained", 32'(out_valid), 32'd0);

    // beq taken, then not taken
    offer(16'h0000, 3'd0, 0, 0, 0, 0);
    ex_branch = 1; ex_zero = 1; ex_branch_target = 16'h0040;
    tick();
    idle_inputs();
    check_val("beq_taken", 32'(branch_taken), 32'd1);
    check_val("beq_target", 32'(branch_target), 32'h0040);
    check_val("beq_entry_stored", 32'(out_valid), 32'd1);
    tick();
    check_val("beq_one_pulse", 32'(branch_taken), 32'd0);
    offer(16'h0001, 3'd0, 0, 0, 0, 0);
    ex_branch = 1; ex_zero = 0; ex_branch_target = 16'h0080;
    tick();
    idle_inputs();
    check_val("beq_not_taken", 32'(branch_taken), 32'd0);
    check_val("beq_target_kept", 32'(branch_target), 32'h0040);
    tick();

    // Load hazard and rd=0 suppression
    out_ready = 0;
    offer(16'h0100, 3'd5, 1, 1, 0, 1);
    tick();
    idle_inputs();
    check_val("load_hazard", 32'(load_hazard), 32'd1);
    check_val("load_no_fwd", 32'(fwd_valid), 32'd0);
    check_val("load_mem_read", 32'(mem_mem_read), 32'd1);
    out_ready = 1;
    tick();
    out_ready = 0;
    offer(16'h0055, 3'd0, 1, 0, 0, 0);
    tick();
    idle_inputs();
    check_val("rd0_valid", 32'(out_valid), 32'd1);
    check_val("rd0_no_fwd", 32'(fwd_valid), 32'd0);
    out_ready = 1;
    tick();

    // Flush at count=2 with a simultaneous offer
    out_ready = 0;
    offer(16'h0201, 3'd1, 0, 0, 1, 0);
    tick();
    offer(16'h0202, 3'd2, 0, 0, 1, 0);
    tick();
    check_val("flush_full", 32'(in_ready), 32'd0);
    offer(16'h0203, 3'd3, 0, 0, 1, 0);
    flush = 1;
    tick();
    idle_inputs();
    check_val("flush_out_valid", 32'(out_valid), 32'd0);
    check_val("flush_in_ready", 32'(in_ready), 32'd1);
    check_val("flush_mem_write_gated", 32'(mem_mem_write), 32'd0);
    tick();
    check_val("flush_nothing_kept", 32'(out_valid), 32'd0);

    // Reset at count=1 with in_valid, out_ready and a taken branch offered
    offer(16'h0077, 3'd7, 1, 0, 1, 0);
    tick();
    check_val("prerst_valid", 32'(out_valid), 32'd1);
    offer(16'h0099, 3'd6, 1, 0, 0, 0);
    ex_branch = 1; ex_zero = 1; ex_branch_target = 16'h0099;
    out_ready = 1;
    reset = 1;
    tick();
    reset = 0;
    idle_inputs();
    check_reset_state("midrst");

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end

endmodule
